// File: rtl/div18_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first,
// with a valid/ready request side and a valid/ready result side.
module div18_seq #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] din1_i,
  input  logic [WIDTH-1:0] din2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dz_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_borrow;
  logic             w_last;

  // r_quot doubles as the dividend shift register: dividend bits leave at
  // the top while quotient bits enter at the bottom.
  assign w_shift  = {r_rem, r_quot[WIDTH-1]};
  assign w_borrow = (w_shift < {1'b0, r_div});
  // Without a borrow the true difference is below the divisor, so the
  // low WIDTH bits of the modular subtraction are exact.
  assign w_sub    = w_shift[WIDTH-1:0] - r_div;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_next = (din2_i == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_div <= din2_i;
            r_cnt <= '0;
            if (din2_i == '0) begin
              r_quot <= '1;
              r_rem  <= din1_i;
              r_dz   <= 1'b1;
            end else begin
              r_quot <= din1_i;
              r_rem  <= '0;
              r_dz   <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          r_cnt  <= r_cnt + CW'(1);
          r_quot <= {r_quot[WIDTH-2:0], ~w_borrow};
          r_rem  <= w_borrow ? w_shift[WIDTH-1:0] : w_sub;
        end
        S_DONE: begin
          if (ready_i) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // During BUSY r_quot still carries dividend bits, so results are gated.
  assign ready_o = (r_state == S_IDLE);
  assign valid_o = (r_state == S_DONE);
  assign quot_o  = valid_o ? r_quot : '0;
  assign rem_o   = valid_o ? r_rem  : '0;
  assign dz_o    = valid_o & r_dz;

endmodule

// File: tb/tb_div18_seq.sv
// Directed bench for div18_seq: hand-computed quotients/remainders, latency,
// divide-by-zero, backpressure, ignored requests and mid-operation reset.
module tb_div18_seq;

  localparam int unsigned W = 18;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] din1_i;
  logic [W-1:0] din2_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] quot_o;
  logic [W-1:0] rem_o;
  logic         dz_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  div18_seq #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .din1_i  (din1_i),
    .din2_i  (din2_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .quot_o  (quot_o),
    .rem_o   (rem_o),
    .dz_o    (dz_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_quot"},  32'(quot_o),  32'd0);
    check({tag, "_rem"},   32'(rem_o),   32'd0);
    check({tag, "_dz"},    32'(dz_o),    32'd0);
  endtask

  // Waits (bounded) for valid_o; n counts edges already seen after E0.
  task automatic wait_result(input string tag, input int start_n, input int elat,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int n;
    n = start_n;
    while (!valid_o && n < 40) begin
      tick;
      n++;
    end
    check({tag, "_lat"},  32'(n),      32'(elat));
    check({tag, "_quot"}, 32'(quot_o), 32'(eq));
    check({tag, "_rem"},  32'(rem_o),  32'(er));
    check({tag, "_dz"},   32'(dz_o),   32'(edz));
  endtask

  // Handshake edge carries a divide-by-zero request that must not be taken.
  task automatic handshake(input string tag);
    ready_i = 1'b1;
    valid_i = 1'b1;
    din1_i  = 18'd5;
    din2_i  = '0;
    tick;
    ready_i = 1'b0;
    valid_i = 1'b0;
    check_idle({tag, "_hs"});
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input int elat, input int hold);
    valid_i = 1'b1;
    din1_i  = a;
    din2_i  = b;
    tick;
    valid_i = 1'b0;
    din1_i  = ~a;
    din2_i  = b ^ 18'h2AAAA;
    check({tag, "_e0_valid"}, 32'(valid_o), 32'(elat == 0));
    check({tag, "_e0_ready"}, 32'(ready_o), 32'd0);
    wait_result(tag, 0, elat, eq, er, edz);
    for (int i = 0; i < hold; i++) begin
      valid_i = 1'b1;
      din1_i  = 18'd5;
      din2_i  = '0;
      tick;
      check({tag, "_bp_valid"}, 32'(valid_o), 32'd1);
      check({tag, "_bp_ready"}, 32'(ready_o), 32'd0);
      check({tag, "_bp_quot"},  32'(quot_o),  32'(eq));
      check({tag, "_bp_rem"},   32'(rem_o),   32'(er));
      check({tag, "_bp_dz"},    32'(dz_o),    32'(edz));
    end
    handshake(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    din1_i  = '0;
    din2_i  = '0;
    tick;
    tick;
    rst_i = 1'b0;
    check_idle("reset");

    do_op("d100_7",    18'd100,    18'd7,     18'd14,    18'd2,   1'b0, 18, 0);
    do_op("max_1",     18'h3FFFF,  18'd1,     18'h3FFFF, 18'd0,   1'b0, 18, 5);
    do_op("d3_10",     18'd3,      18'd10,    18'd0,     18'd3,   1'b0, 18, 0);
    do_op("d5_0",      18'd5,      18'd0,     18'h3FFFF, 18'd5,   1'b1, 0,  2);
    do_op("max_max",   18'h3FFFF,  18'h3FFFF, 18'd1,     18'd0,   1'b0, 18, 0);
    do_op("max_1000",  18'd262143, 18'd1000,  18'd262,   18'd143, 1'b0, 18, 0);

    // New requests pulsed during BUSY must be ignored.
    valid_i = 1'b1;
    din1_i  = 18'd1000;
    din2_i  = 18'd33;
    tick;
    valid_i = 1'b0;
    repeat (4) tick;
    valid_i = 1'b1;
    din1_i  = 18'd7;
    din2_i  = '0;
    tick;
    din1_i  = 18'd9;
    din2_i  = 18'd3;
    tick;
    valid_i = 1'b0;
    check("busy_pulse_ready", 32'(ready_o), 32'd0);
    wait_result("busy_pulse", 6, 18, 18'd30, 18'd10, 1'b0);
    handshake("busy_pulse");

    // Reset on the ninth BUSY step discards the operation.
    valid_i = 1'b1;
    din1_i  = 18'd50000;
    din2_i  = 18'd123;
    tick;
    valid_i = 1'b0;
    repeat (8) tick;
    rst_i   = 1'b1;
    ready_i = 1'b1;
    tick;
    rst_i   = 1'b0;
    ready_i = 1'b0;
    check_idle("rst_busy");
    tick;
    check("rst_busy_novalid", 32'(valid_o), 32'd0);
    do_op("after_rst", 18'd50000, 18'd123, 18'd406, 18'd62, 1'b0, 18, 0);

    // Reset wins over a handshake and a new request on the same edge.
    valid_i = 1'b1;
    din1_i  = 18'd7;
    din2_i  = '0;
    tick;
    check("dz_pre_rst_valid", 32'(valid_o), 32'd1);
    rst_i   = 1'b1;
    ready_i = 1'b1;
    din1_i  = 18'd9;
    din2_i  = 18'd3;
    tick;
    rst_i   = 1'b0;
    ready_i = 1'b0;
    valid_i = 1'b0;
    check_idle("rst_done");
    do_op("d0_9", 18'd0, 18'd9, 18'd0, 18'd0, 1'b0, 18, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div18_seq.md
DIV18_SEQ -- requirements
Module: div18_seq

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 18, giving the operand and result width in bits; all values below assume WIDTH=18.
Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk_i, input, 1: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port valid_i, input, 1: operand request valid.
REQ-005 The block SHALL have port ready_o, output, 1: block can accept a request.
REQ-006 The block SHALL have port din1_i, input, WIDTH: unsigned dividend.
REQ-007 The block SHALL have port din2_i, input, WIDTH: unsigned divisor.
REQ-008 The block SHALL have port valid_o, output, 1: result valid.
REQ-009 The block SHALL have port ready_i, input, 1: downstream accepts result.
REQ-010 The block SHALL have port quot_o, output, WIDTH: quotient.
REQ-011 The block SHALL have port rem_o, output, WIDTH: remainder.
REQ-012 The block SHALL have port dz_o, output, 1: divide-by-zero flag, qualified by valid_o.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 The block SHALL drive ready_o=1 only in IDLE; the request is accepted on an edge where valid_i=1 and ready_o=1 (edge E0).
REQ-015 On acceptance, the block SHALL register din1_i and din2_i; later changes on those inputs SHALL NOT affect the result.
REQ-016 On acceptance with din2_i!=0, the block SHALL enter BUSY, clear the partial remainder to 0 and clear the step counter to 0.
REQ-017 Each BUSY edge SHALL perform one restoring step, MSB first: shift the next dividend bit into the partial remainder (WIDTH+1 bits wide), subtract the divisor, keep the difference and set the quotient bit to 1 if no borrow results, otherwise keep the old remainder and set the quotient bit to 0.
REQ-018 After exactly WIDTH steps the block SHALL enter DONE; valid_o SHALL be 1 after edge E18 and not before.
REQ-019 On acceptance with din2_i==0, the block SHALL go to DONE on E0 (valid_o=1 after E1 timing is NOT used; valid_o=1 immediately after E0) with quot_o=all ones (0x3FFFF), rem_o=din1_i and dz_o=1.
REQ-020 In DONE, quot_o, rem_o, dz_o and valid_o SHALL hold stable until an edge with ready_i=1, which SHALL move the FSM to IDLE with valid_o=0.
REQ-021 The block SHALL NOT accept a new request in the same cycle as the result handshake; the next request is accepted no earlier than the following edge.
REQ-022 valid_i asserted in BUSY or DONE SHALL be ignored and SHALL NOT corrupt the state or the result.
REQ-023 For a normal result, dz_o SHALL be 0, quot_o*din2 + rem_o SHALL equal din1, and rem_o SHALL be less than din2.
REQ-024 Outside DONE, quot_o and rem_o SHALL be 0.
REQ-025 Internal arithmetic SHALL NOT overflow for any operand pair, including 0x3FFFF/0x3FFFF and 0x3FFFF/1.

Reset
REQ-026 An edge with rst_i=1 SHALL force IDLE, valid_o=0, quot_o=0, rem_o=0, dz_o=0 and step counter=0, so that ready_o=1 after that edge.
REQ-027 Reset SHALL take priority over any handshake on the same edge, and a reset during BUSY or DONE SHALL discard the operation in progress without producing a result.

Verification
REQ-028 The bench SHALL check din1=100, din2=7 accepted at E0 -> valid_o=1 after E18 with quot_o=14, rem_o=2, dz_o=0.
REQ-029 The bench SHALL check din1=0x3FFFF, din2=1 -> quot_o=0x3FFFF, rem_o=0; then din1=3, din2=10 -> quot_o=0, rem_o=3.
REQ-030 The bench SHALL check din1=5, din2=0 -> valid_o=1 after E0 with quot_o=0x3FFFF, rem_o=5, dz_o=1.
REQ-031 The bench SHALL check backpressure: hold ready_i=0 for 5 cycles in DONE -> outputs stable and ready_o=0; then assert ready_i -> IDLE on the next edge, then accept a back-to-back request.
REQ-032 The bench SHALL check valid_i pulsed with new operands during BUSY -> ignored, and the first result is unchanged.
REQ-033 The bench SHALL check rst_i=1 at step 9 of BUSY -> after that edge valid_o=0, ready_o=1, all outputs 0, and the next request completes correctly.
